eater_core: RTL

EATER_CORE -- requirements
Module: eater_core

---
 rtl/eater_core.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/eater_core.sv
// eater_core: SAP-style accumulator CPU with a single synchronous-read RAM.
// Define EATER_LOAD_PORT_EN to add a RAM load port that is live only in HALT.
module eater_core #(
  parameter int    DATA_W      = 8,
  parameter int    RESET_PC    = 0,
  parameter string PROGRAM_HEX = "build/program.hex",
  localparam int   ADDR_W      = DATA_W - 4
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              run_i,
`ifdef EATER_LOAD_PORT_EN
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
`endif
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              halted_o,
  output logic [ADDR_W-1:0] pc_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_OUT, S_HALT
  } state_e;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                z_q, z_d;
  logic                c_q, c_d;
  logic                ov_q, ov_d;
  logic [DATA_W-1:0]   od_q, od_d;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic [DATA_W-1:0]   rdata_q;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [3:0]          opc;
  logic [ADDR_W-1:0]   oper;
  logic                sub;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W:0]     alu;

  assign opc   = ir_q[DATA_W-1 -: 4];
  assign oper  = ir_q[ADDR_W-1:0];
  // SUB is A + ~B + 1, so the carry out means "no borrow"
  assign sub   = (opc == OP_SUB);
  assign alu_b = sub ? ~rdata_q : rdata_q;
  assign alu   = {1'b0, a_q} + {1'b0, alu_b}
               + {{DATA_W{1'b0}}, sub};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    b_d       = b_q;
    ir_d      = ir_q;
    z_d       = z_q;
    c_d       = c_q;
    ov_d      = ov_q;
    od_d      = od_q;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = a_q;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = rdata_q;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        mem_addr = oper;
        state_d  = S_FETCH;
        case (opc)
          OP_LDA, OP_ADD, OP_SUB: state_d = S_MEM;
          OP_STA: mem_we = 1'b1;
          OP_LDI: a_d = {4'h0, oper};
          OP_JMP: pc_d = oper;
          OP_JC:  if (c_q) pc_d = oper;
          OP_JZ:  if (z_q) pc_d = oper;
          OP_OUT: begin
            state_d = S_OUT;
            ov_d    = 1'b1;
            od_d    = a_q;
          end
          OP_HLT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_MEM: begin
        state_d = S_FETCH;
        if (opc == OP_LDA) begin
          a_d = rdata_q;
        end else begin
          b_d = rdata_q;
          a_d = alu[DATA_W-1:0];
          c_d = alu[DATA_W];
          z_d = (alu[DATA_W-1:0] == '0);
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          ov_d    = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (run_i) state_d = S_FETCH;
`ifdef EATER_LOAD_PORT_EN
        mem_we    = load_we_i;
        mem_addr  = load_addr_i;
        mem_wdata = load_data_i;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      a_q     <= '0;
      b_q     <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

  // RAM has no reset so programs survive a reset
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
    rdata_q <= mem_q[mem_addr];
  end

  assign out_data_o  = od_q;
  assign out_valid_o = ov_q;
  assign halted_o    = (state_q == S_HALT);
  assign pc_o        = pc_q;

endmodule
